fifo_rd_arbiter: RTL and testbench

- Round-robin read arbiter that shares the single read port of one asymmetric FIFO among NUM_REQ consumers.
- Grants reads in bursts of up to BURST_LEN words per requester, then rotates to the next requester.
- Returns FIFO read data to the owning requester one cycle after the read is accepted, tagged with the requester id.
- Sits between the accelerator's consumer engines and the FIFO read-side handshake (read_req, read_ready, read_data; data valid the cycle after an accepted read).

---
 rtl/fifo_rd_arbiter_pkg.sv | 37 +++
 rtl/fifo_rd_arbiter_if.sv | 32 +++
 rtl/fifo_rd_arbiter_rr_priority_pick.sv | 37 +++
 rtl/fifo_rd_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_rd_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read arbiter.
//   arb_state_e : arbiter FSM state (IDLE arbitrates, BURST owns the read port)
//   rr_pick     : behavioural round-robin pick (first set bit at or above ptr, with wrap).
//                 The arbiter uses rr_priority_pick for the same job. This function is
//                 available to other blocks, such as the write-side arbiter.
package fifo_rd_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int MAX_REQ  = 32;
   localparam int MAX_ID_W = $clog2(MAX_REQ);

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input int unsigned n,
                                        input int unsigned ptr);
      rr_pick_t r;
      r = '0;
      for (int unsigned k = 0; k < n; k++) begin
         int unsigned j;
         j = (ptr + k) % n;
         if (!r.found && req[j]) begin
            r.found = 1'b1;
            r.idx   = MAX_ID_W'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the consumer engines, the arbiter and the FIFO.
//   req/grant/accept : per-requester request, ownership and accepted-read pulse
//   fifo_read_*      : FIFO read handshake (data valid the cycle after an accept)
//   rsp_*            : read data returned to the owner, tagged with its id
//   busy             : arbiter is in a burst
// Modport master is the arbiter side. Modport slave is the requesters plus the FIFO.
interface fifo_rd_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ID_W       = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    accept;
   logic                  fifo_read_req;
   logic                  fifo_read_ready;
   logic [DATA_WIDTH-1:0] fifo_read_data;
   logic                  rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  busy;

   modport master (
      input  req, fifo_read_ready, fifo_read_data,
      output grant, accept, fifo_read_req, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      output req, fifo_read_ready, fifo_read_data,
      input  grant, accept, fifo_read_req, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/fifo_rd_arbiter_rr_priority_pick.sv
// Combinational round-robin priority pick.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   idx_o   : first set request at or above ptr_i, with wrap-around
//   found_o : at least one request is set
// The block rotates so that ptr_i lands on bit 0, finds the first set bit, and then
// un-rotates by adding ptr_i back. N is a power of two, so the add wraps naturally.
module rr_priority_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;

   always_comb begin
      dbl     = {req_i, req_i} >> ptr_i;
      rot     = dbl[N-1:0];
      off     = '0;
      found_o = 1'b0;
      // Scan downward so that the lowest set bit wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off     = IW'(i);
            found_o = 1'b1;
         end
      end
      idx_o = ptr_i + off;
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter that shares one FIFO read port among NUM_REQ consumers.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fifo_rd_arbiter_if.master (requests, grant, accept, FIFO read
//                handshake, tagged response, busy)
// Each grant allows at most BURST_LEN accepted reads. One IDLE cycle of arbitration
// sits between bursts. Read data is passed straight through to the response, and
// rsp_valid/rsp_id are registered so that they line up with it.
module fifo_rd_arbiter
   import fifo_rd_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 64,
   parameter  int BURST_LEN  = 4,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
   input logic               clk,
   input logic               reset,
   fifo_rd_arbiter_if.master bus
);

   if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
      $error("NUM_REQ must be a power of two and at least 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("BURST_LEN must be at least 1");
   end

   arb_state_e            state_q;
   logic [ID_W-1:0]       owner_q;
   logic [ID_W-1:0]       rr_ptr_q;
   logic [CNT_W-1:0]      burst_cnt_q;
   logic [CNT_W-1:0]      burst_cnt_d;
   logic [NUM_REQ-1:0]    grant_q;
   logic                  rsp_valid_q;
   logic [ID_W-1:0]       rsp_id_q;

   logic [ID_W-1:0]       pick_idx;
   logic                  pick_found;
   logic                  rd_req;
   logic                  rd_acc;
   logic                  burst_last;
   logic [DATA_WIDTH-1:0] rd_data;

   rr_priority_pick #(.N(NUM_REQ)) u_pick (
      .req_i   (bus.req),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // The owner's request is forwarded to the FIFO. An accept is that request meeting ready.
   assign rd_req      = (state_q == BURST) && bus.req[owner_q];
   assign rd_acc      = rd_req && bus.fifo_read_ready;
   assign burst_cnt_d = burst_cnt_q + CNT_W'(1);
   assign burst_last  = (burst_cnt_d == CNT_W'(BURST_LEN));
   assign rd_data     = bus.fifo_read_data;

   assign bus.grant         = grant_q;
   assign bus.accept        = rd_acc ? grant_q : '0;
   assign bus.fifo_read_req = rd_req;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_data      = rd_data;
   assign bus.busy          = (state_q == BURST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         grant_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         // Response stage: the FIFO presents the word one cycle after the accept.
         rsp_valid_q <= rd_acc;
         rsp_id_q    <= owner_q;

         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  owner_q     <= pick_idx;
                  burst_cnt_q <= '0;
                  grant_q     <= NUM_REQ'(1) << pick_idx;
                  state_q     <= BURST;
               end
            end
            BURST: begin
               if (rd_acc) begin
                  burst_cnt_q <= burst_cnt_d;
               end
               // Stay only while reads keep being accepted below the burst limit.
               // A dropped request and a FIFO with no word available both end the
               // burst, so an owner cannot hold an empty FIFO.
               if (!rd_acc || burst_last) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= owner_q + ID_W'(1);
               end
            end
         endcase
      end
   end

   a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(bus.grant));
   a_accept_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(bus.accept));

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter. The stimulus process plays directed per-cycle vectors
// and pushes the expected tagged responses into a queue. A monitor pops that queue
// whenever rsp_valid is high. The closing random phase checks one-hot grants,
// accept gating, starvation bounds and per-id data ordering.
module tb_fifo_rd_arbiter;
   localparam int NR = 4;
   localparam int DW = 64;
   localparam int BL = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_rd_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
   } rsp_t;

   int          n_chk = 0;
   int          n_err = 0;
   rsp_t        exp_q[$];
   logic [63:0] fifo_word = '0;
   logic [63:0] base;
   bit          rand_mode = 1'b0;
   logic [DW-1:0] last_data [NR];
   bit          seen [NR];
   logic [NR-1:0] prev_exp_acc = '0;
   logic [NR-1:0] g;
   logic [NR-1:0] r;
   logic          rdy;
   int            wcnt [NR];
   bit            armed [NR];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [1:0] id, input logic [63:0] data);
      rsp_t e;
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // FIFO model: it always holds data. Each accepted read returns the next counter value.
   always @(posedge clk) begin
      if (bus.fifo_read_req === 1'b1 && bus.fifo_read_ready === 1'b1) begin
         bus.fifo_read_data <= fifo_word;
         fifo_word          <= fifo_word + 64'd1;
      end
   end

   // Response monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            if (rand_mode) begin
               if (seen[bus.rsp_id]) chk("rnd.id_order", 64'(bus.rsp_data > last_data[bus.rsp_id]), 64'd1);
               seen[bus.rsp_id]      = 1'b1;
               last_data[bus.rsp_id] = bus.rsp_data;
            end else begin
               chk("rsp.pending", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  rsp_t e;
                  e = exp_q.pop_front();
                  chk("rsp.id", 64'(bus.rsp_id), 64'(e.id));
                  chk("rsp.data", bus.rsp_data, e.data);
               end
            end
         end
      end
   end

   // One directed cycle: apply the inputs at negedge, then check this cycle's outputs.
   task automatic step(input logic [NR-1:0] rq, input logic rd, input logic rs,
                       input logic [NR-1:0] eg, input logic [NR-1:0] ea, input string tag);
      @(negedge clk);
      bus.req             = rq;
      bus.fifo_read_ready = rd;
      reset               = rs;
      #1;
      chk({tag, ".grant"}, 64'(bus.grant), 64'(eg));
      chk({tag, ".accept"}, 64'(bus.accept), 64'(ea));
      chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(|prev_exp_acc));
      chk({tag, ".busy"}, 64'(bus.busy), 64'(|eg));
      prev_exp_acc = rs ? '0 : ea;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset               = 1'b1;
      bus.req             = '0;
      bus.fifo_read_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, ".rst_grant"}, 64'(bus.grant), 64'd0);
      chk({tag, ".rst_accept"}, 64'(bus.accept), 64'd0);
      chk({tag, ".rst_rdreq"}, 64'(bus.fifo_read_req), 64'd0);
      chk({tag, ".rst_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, ".rst_rsp_id"}, 64'(bus.rsp_id), 64'd0);
      chk({tag, ".rst_busy"}, 64'(bus.busy), 64'd0);
      prev_exp_acc = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req             = '0;
      bus.fifo_read_ready = 1'b0;

      // Single requester: bursts on cycles 1-4 and 6-9, with arbitration on cycles 0 and 5.
      do_reset("t1");
      base = fifo_word;
      for (int k = 0; k < 8; k++) push_exp(2'd0, base + 64'(k));
      for (int c = 0; c < 10; c++) begin
         g = (c == 0 || c == 5) ? 4'b0000 : 4'b0001;
         step(4'b0001, 1'b1, 1'b0, g, g, "t1");
      end
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t1");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t1");

      // All four requesters active: grant order 0,1,2,3,0 with 4 accepts per grant.
      do_reset("t2");
      base = fifo_word;
      for (int j = 0; j < 17; j++) push_exp(2'((j / 4) % 4), base + 64'(j));
      for (int c = 0; c < 22; c++) begin
         g = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
         step(4'b1111, 1'b1, 1'b0, g, g, "t2");
      end
      step(4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, "t2");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t2");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t2");

      // Owner 1 drops its request after 2 accepts. rr_ptr moves to 2, so 2 beats 0.
      do_reset("t3");
      base = fifo_word;
      push_exp(2'd1, base);
      push_exp(2'd1, base + 64'd1);
      push_exp(2'd2, base + 64'd2);
      step(4'b0110, 1'b1, 1'b0, 4'b0000, 4'b0000, "t3");
      step(4'b0110, 1'b1, 1'b0, 4'b0010, 4'b0010, "t3");
      step(4'b0110, 1'b1, 1'b0, 4'b0010, 4'b0010, "t3");
      step(4'b0101, 1'b1, 1'b0, 4'b0010, 4'b0000, "t3");
      step(4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, "t3");
      step(4'b0101, 1'b1, 1'b0, 4'b0100, 4'b0100, "t3");
      step(4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, "t3");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t3");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t3");

      // FIFO empties after 1 accept. Owner 0 yields, and requester 1 is served before 0.
      do_reset("t4");
      base = fifo_word;
      push_exp(2'd0, base);
      for (int k = 1; k < 5; k++) push_exp(2'd1, base + 64'(k));
      push_exp(2'd0, base + 64'd5);
      step(4'b0011, 1'b1, 1'b0, 4'b0000, 4'b0000, "t4");
      step(4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0001, "t4");
      step(4'b0011, 1'b0, 1'b0, 4'b0001, 4'b0000, "t4");
      step(4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, "t4");
      for (int c = 0; c < 4; c++) step(4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0010, "t4");
      step(4'b0011, 1'b1, 1'b0, 4'b0000, 4'b0000, "t4");
      step(4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0001, "t4");
      step(4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, "t4");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t4");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t4");

      // Reset lands on the 3rd accept. That word is consumed but never returned.
      do_reset("t5");
      base = fifo_word;
      push_exp(2'd0, base);
      push_exp(2'd0, base + 64'd1);
      push_exp(2'd3, base + 64'd3);
      step(4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, "t5");
      step(4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, "t5");
      step(4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, "t5");
      step(4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, "t5");
      step(4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t5");
      chk("t5.rsp_id_after_reset", 64'(bus.rsp_id), 64'd0);
      chk("t5.rdreq_after_reset", 64'(bus.fifo_read_req), 64'd0);
      step(4'b1000, 1'b1, 1'b0, 4'b1000, 4'b1000, "t5");
      step(4'b0000, 1'b1, 1'b0, 4'b1000, 4'b0000, "t5");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t5");
      step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, "t5");
      chk("directed.queue_drained", 64'(exp_q.size()), 64'd0);

      // Random request/ready traffic.
      do_reset("rnd");
      rand_mode = 1'b1;
      for (int i = 0; i < NR; i++) begin
         seen[i]  = 1'b0;
         wcnt[i]  = 0;
         armed[i] = 1'b0;
      end
      r = 4'b1111;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         rdy                 = ($urandom_range(0, 3) != 0);
         bus.req             = r;
         bus.fifo_read_ready = rdy;
         #1;
         chk("rnd.grant_onehot", 64'($onehot0(bus.grant)), 64'd1);
         chk("rnd.accept", 64'(bus.accept), 64'(rdy ? (bus.grant & r) : 4'b0000));
         for (int i = 0; i < NR; i++) begin
            if (bus.grant[i] || !r[i]) begin
               armed[i] = 1'b0;
               wcnt[i]  = 0;
            end else begin
               if (!bus.busy) armed[i] = 1'b1;
               if (armed[i]) begin
                  wcnt[i]++;
                  chk("rnd.starvation", 64'(wcnt[i] <= (NR - 1) * (BL + 1) + 1), 64'd1);
               end
            end
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.req = '0;
      end
      rand_mode = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
